// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore-style control FSM for a multi-cycle MIPS datapath with a shared ALU
//   and a shared memory. It steps through a fixed state sequence for each
//   opcode and supports R-type, lw, sw, beq, bne and j. It stalls on a
//   single memory-ready handshake and counts retired instructions.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   MEM_WAIT_EN  1: memory states wait for mem_ready; 0: mem_ready is ignored
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   opcode            instr[31:26]; used from DECODE onward
//   mem_ready         memory access completes this cycle
//   PCWrite .. Ne     datapath control strobes and selects (decoded from state)
//   state             current state code, for debug
//   illegal           high while in the trap state
//   instr_count       retired-instruction count (wraps)
module multicycle_control #(
    parameter int unsigned CNT_W       = 32,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       AluOP,
    output logic [1:0]       PCSource,
    output logic             Ne,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StTrap   = 4'd10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdy;
    logic             retire;

    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  state_d = rdy ? StDecode : StFetch;
            StDecode: begin
                if (opcode == OpRType) begin
                    state_d = StExec;
                end else if (opcode == OpLw || opcode == OpSw) begin
                    state_d = StMemAdr;
                end else if (opcode == OpBeq || opcode == OpBne) begin
                    state_d = StBranch;
                end else if (opcode == OpJ) begin
                    state_d = StJump;
                end else begin
                    state_d = StTrap;
                end
            end
            // Opcode is held from DECODE, so only lw/sw can reach here.
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = rdy ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = rdy ? StFetch : StMemWr;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH from a final state.
    always_comb begin
        retire = 1'b0;
        if (state_d == StFetch) begin
            case (state_q)
                StMemWb, StMemWr, StAluWb, StBranch, StJump: retire = 1'b1;
                default:                                     retire = 1'b0;
            endcase
        end
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Output decode: Moore outputs, with mem_ready qualifying the FETCH loads
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        AluOP       = 2'b00;
        PCSource    = 2'b00;
        Ne          = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
            end
            StDecode: ALUSrcB = 2'b11;
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                AluOP   = 2'b10;
            end
            StAluWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                AluOP       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Ne          = (opcode == OpBne);
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            StTrap:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Scoreboard bench for multicycle_control (CNT_W=4 so the counter wraps).
//   The stimulus process walks each instruction through the state sequence
//   its opcode implies, pushing the expected per-cycle response; a monitor
//   pops one entry per cycle and compares it with the DUT outputs.
module tb_multicycle_control;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_MEMADR = 2;
    localparam int S_MEMRD  = 3;
    localparam int S_MEMWB  = 4;
    localparam int S_MEMWR  = 5;
    localparam int S_EXEC   = 6;
    localparam int S_ALUWB  = 7;
    localparam int S_BRANCH = 8;
    localparam int S_JUMP   = 9;
    localparam int S_TRAP   = 10;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ne;
    } ctrl_t;

    typedef struct {
        int         st;
        ctrl_t      ctrl;
        logic       ill;
        logic [3:0] cnt;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Ne, illegal;
    logic [1:0] ALUSrcB, AluOP, PCSource;
    logic [3:0] state;
    logic [3:0] instr_count;

    rec_t       sb_q[$];
    logic [3:0] exp_cnt;
    int         total = 0;
    int         bad = 0;

    multicycle_control #(
        .CNT_W       (4),
        .MEM_WAIT_EN (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .AluOP       (AluOP),
        .PCSource    (PCSource),
        .Ne          (Ne),
        .state       (state),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Control values each state must present, straight from the state table.
    function automatic ctrl_t exp_ctrl(int st, logic rdy, logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = rdy;
                c.pc_write  = rdy;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.ne            = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    // One clock cycle: record what the DUT must show, drive inputs, advance.
    task automatic cycle(input int st, input logic rdy, input logic [5:0] op, input logic rst);
        rec_t r;
        r.st   = st;
        r.ctrl = exp_ctrl(st, rdy, op);
        r.ill  = (st == S_TRAP);
        r.cnt  = exp_cnt;
        sb_q.push_back(r);
        reset     = rst;
        mem_ready = rdy;
        opcode    = op;
        @(posedge clk);
        #1;
    endtask

    // One instruction. nst < 0 picks a random stall count for each wait state.
    task automatic run_instr(input logic [5:0] op, input int nst, input bit abort);
        int s;
        s = (nst < 0) ? int'($urandom_range(0, 2)) : nst;
        repeat (s) cycle(S_FETCH, 1'b0, 6'($urandom), 1'b0);
        cycle(S_FETCH, 1'b1, 6'($urandom), 1'b0);
        cycle(S_DECODE, 1'($urandom), op, 1'b0);
        if (op == OP_R) begin
            cycle(S_EXEC, 1'($urandom), op, 1'b0);
            cycle(S_ALUWB, 1'($urandom), op, 1'b0);
            exp_cnt = exp_cnt + 4'd1;
        end else if (op == OP_LW) begin
            cycle(S_MEMADR, 1'($urandom), op, 1'b0);
            if (abort) begin
                cycle(S_MEMRD, 1'($urandom), op, 1'b1);
                exp_cnt = 4'd0;
            end else begin
                repeat (s) cycle(S_MEMRD, 1'b0, op, 1'b0);
                cycle(S_MEMRD, 1'b1, op, 1'b0);
                cycle(S_MEMWB, 1'($urandom), op, 1'b0);
                exp_cnt = exp_cnt + 4'd1;
            end
        end else if (op == OP_SW) begin
            cycle(S_MEMADR, 1'($urandom), op, 1'b0);
            repeat (s) cycle(S_MEMWR, 1'b0, op, 1'b0);
            cycle(S_MEMWR, 1'b1, op, 1'b0);
            exp_cnt = exp_cnt + 4'd1;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            cycle(S_BRANCH, 1'($urandom), op, 1'b0);
            exp_cnt = exp_cnt + 4'd1;
        end else if (op == OP_J) begin
            cycle(S_JUMP, 1'($urandom), op, 1'b0);
            exp_cnt = exp_cnt + 4'd1;
        end else begin
            // Trap holds until reset; the last trap cycle carries the reset.
            repeat (5) cycle(S_TRAP, 1'($urandom), op, 1'b0);
            cycle(S_TRAP, 1'($urandom), op, 1'b1);
            exp_cnt = 4'd0;
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        rec_t  r;
        ctrl_t act;
        if (sb_q.size() > 0) begin
            r   = sb_q.pop_front();
            act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, AluOP, PCSource, Ne};
            total++;
            if (int'(state) != r.st) begin
                bad++;
                $display("FAIL state t=%0t got=%0d want=%0d", $time, state, r.st);
            end
            total++;
            if (act !== r.ctrl) begin
                bad++;
                $display("FAIL ctrl t=%0t st=%0d got=%05h want=%05h", $time, r.st, act, r.ctrl);
            end
            total++;
            if (illegal !== r.ill) begin
                bad++;
                $display("FAIL illegal t=%0t got=%0b want=%0b", $time, illegal, r.ill);
            end
            total++;
            if (instr_count !== r.cnt) begin
                bad++;
                $display("FAIL instr_count t=%0t got=%0d want=%0d", $time, instr_count, r.cnt);
            end
        end
    end

    initial begin
        logic [5:0] op;
        int         k;
        exp_cnt   = 4'd0;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        @(posedge clk);
        #1;
        // Second reset cycle: FETCH already, reset outranks mem_ready.
        cycle(S_FETCH, 1'b1, 6'd0, 1'b1);

        run_instr(OP_R, 0, 1'b0);
        run_instr(OP_LW, 2, 1'b0);
        run_instr(OP_SW, 0, 1'b0);
        run_instr(OP_BNE, 0, 1'b0);
        run_instr(6'b111111, 0, 1'b0);
        run_instr(OP_LW, 0, 1'b1);
        repeat (16) run_instr(OP_J, 0, 1'b0);
        run_instr(OP_BEQ, 1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            k = int'($urandom_range(0, 19));
            case (k)
                0, 1, 2, 17:  op = OP_R;
                3, 4, 5, 18:  op = OP_LW;
                6, 7, 8, 19:  op = OP_SW;
                9, 10:        op = OP_BEQ;
                11, 12:       op = OP_BNE;
                13, 14, 15:   op = OP_J;
                default: begin
                    op = 6'($urandom);
                    if (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                        op == OP_BNE || op == OP_J) begin
                        op = 6'b111111;
                    end
                end
            endcase
            run_instr(op, -1, (op == OP_LW) && ($urandom_range(0, 9) == 0));
        end
        cycle(S_FETCH, 1'b0, 6'd0, 1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
